// File: rtl/watch_time_core.sv
// Timekeeping core: synchronises the 1 kHz tick, counts ms into BCD hh:mm:ss, supports field setting.
// Optional macro WATCH_12H_EN selects a 12-hour display with pm flag; otherwise 24-hour count.
module watch_time_core #(
    parameter int unsigned TICKS_PER_SEC = 1000,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic       clk_50Mhz,
    input  logic       rst,
    input  logic       clk_1Khz,
    input  logic [1:0] set_mode,
    input  logic       inc_pulse,
    output logic [3:0] hr_tens,
    output logic [3:0] hr_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [9:0] ms_cnt,
    output logic       sec_tick,
    output logic       pm
);

    localparam int unsigned MS_W = 10;
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(TICKS_PER_SEC - 1);

`ifdef WATCH_12H_EN
    localparam logic [7:0] HR_RST = 8'h12;
`else
    localparam logic [7:0] HR_RST = 8'h00;
`endif

    typedef enum logic [1:0] {
        MODE_RUN = 2'b00,
        MODE_HR  = 2'b01,
        MODE_MIN = 2'b10,
        MODE_SEC = 2'b11
    } mode_e;

    mode_e mode_c;
    assign mode_c = mode_e'(set_mode);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   tick_q;

    logic [7:0]      hr_n, min_n, sec_n;
    logic [MS_W-1:0] ms_n;
    logic            sec_tick_n;

    // BCD increment of a 00..59 field
    function automatic logic [7:0] inc60(input logic [7:0] v);
        if (v[3:0] != 4'd9)      return {v[7:4], 4'(v[3:0] + 4'd1)};
        else if (v[7:4] != 4'd5) return {4'(v[7:4] + 4'd1), 4'd0};
        else                     return 8'h00;
    endfunction

    // BCD increment of the hours field (12-hour: 12,01..11; 24-hour: 00..23)
    function automatic logic [7:0] inc_hr(input logic [7:0] v);
`ifdef WATCH_12H_EN
        if (v == 8'h12)          return 8'h01;
`else
        if (v == 8'h23)          return 8'h00;
`endif
        else if (v[3:0] == 4'd9) return {4'(v[7:4] + 4'd1), 4'd0};
        else                     return {v[7:4], 4'(v[3:0] + 4'd1)};
    endfunction

    // Tick is registered so it lands SYNC_STAGES+1 edges after the 1 kHz rise
    always_ff @(posedge clk_50Mhz or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            edge_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], clk_1Khz};
            edge_q <= sync_q[SYNC_STAGES-1];
            tick_q <= sync_q[SYNC_STAGES-1] & ~edge_q;
        end
    end

`ifdef WATCH_12H_EN
    logic pm_q, pm_n;
    assign pm = pm_q;
`else
    assign pm = 1'b0;
`endif

    // Next-state: run-mode carry chain or set-mode field increment
    always_comb begin
        hr_n       = {hr_tens, hr_ones};
        min_n      = {min_tens, min_ones};
        sec_n      = {sec_tens, sec_ones};
        ms_n       = ms_cnt;
        sec_tick_n = 1'b0;
`ifdef WATCH_12H_EN
        pm_n       = pm_q;
`endif
        unique case (mode_c)
            MODE_RUN: begin
                if (tick_q) begin
                    if (ms_cnt < MS_LAST) begin
                        ms_n = ms_cnt + 10'd1;
                    end else begin
                        ms_n       = '0;
                        sec_tick_n = 1'b1;
                        sec_n      = inc60({sec_tens, sec_ones});
                        if ({sec_tens, sec_ones} == 8'h59) begin
                            min_n = inc60({min_tens, min_ones});
                            if ({min_tens, min_ones} == 8'h59) begin
                                hr_n = inc_hr({hr_tens, hr_ones});
`ifdef WATCH_12H_EN
                                if ({hr_tens, hr_ones} == 8'h11) pm_n = ~pm_q;
`endif
                            end
                        end
                    end
                end
            end
            MODE_HR: begin
                ms_n = '0;
                if (inc_pulse) begin
                    hr_n = inc_hr({hr_tens, hr_ones});
`ifdef WATCH_12H_EN
                    if ({hr_tens, hr_ones} == 8'h11) pm_n = ~pm_q;
`endif
                end
            end
            MODE_MIN: begin
                ms_n = '0;
                if (inc_pulse) min_n = inc60({min_tens, min_ones});
            end
            MODE_SEC: begin
                ms_n = '0;
                if (inc_pulse) sec_n = inc60({sec_tens, sec_ones});
            end
        endcase
    end

    // Time and sub-second registers
    always_ff @(posedge clk_50Mhz or posedge rst) begin
        if (rst) begin
            {hr_tens, hr_ones}   <= HR_RST;
            {min_tens, min_ones} <= 8'h00;
            {sec_tens, sec_ones} <= 8'h00;
            ms_cnt               <= '0;
            sec_tick             <= 1'b0;
        end else begin
            {hr_tens, hr_ones}   <= hr_n;
            {min_tens, min_ones} <= min_n;
            {sec_tens, sec_ones} <= sec_n;
            ms_cnt               <= ms_n;
            sec_tick             <= sec_tick_n;
        end
    end

`ifdef WATCH_12H_EN
    always_ff @(posedge clk_50Mhz or posedge rst) begin
        if (rst) pm_q <= 1'b0;
        else     pm_q <= pm_n;
    end
`endif

endmodule
